spi_flash_rd_seq: RTL and testbench

- Hardware sequencer that performs a standard SPI-flash READ (opcode 0x03) through the existing SPI peripheral's register port.
- Acts as the sole master of the SPI register port: it owns CS, loads bytes, kicks transfers, polls busy and collects receive bytes.
- Sits between the boot/loader logic (command side) and the SPI peripheral, so firmware need not bit-manage flash reads.

---
 rtl/spi_flash_rd_seq.sv | 144 ++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: drives a SPI-flash READ (0x03) through the SPI peripheral register port
module spi_flash_rd_seq #(
    parameter logic [7:0] SPI_CTRL_ADDR = 8'h00,
    parameter logic [7:0] SPI_DATA_ADDR = 8'h04,
    parameter logic [7:0] SPI_STAT_ADDR = 8'h08
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [7:0]  clk_div_i,
    output logic        busy_o,
    output logic [7:0]  rdata_o,
    output logic        rvalid_o,
    output logic        done_o,
    output logic [7:0]  spi_waddr_o,
    output logic [31:0] spi_wdata_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_we_o,
    output logic [7:0]  spi_raddr_o,
    output logic        spi_rd_o,
    input  logic [31:0] spi_rdata_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_LOAD, S_KICK, S_WB_RD, S_WB_CHK,
        S_WI_RD, S_WI_CHK, S_DR, S_DCHK, S_CS_OFF, S_FIN
    } state_t;

    state_t      r_state;
    logic [23:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_div;
    logic [8:0]  r_idx;
    logic [8:0]  w_last;
    logic [23:0] w_unused_rdata;

    assign w_last = (r_len == 8'd0) ? 9'd259 : {1'b0, r_len} + 9'd3;
    assign w_unused_rdata = spi_rdata_i[31:8];

    function automatic logic [7:0] f_byte(input logic [8:0] i, input logic [23:0] a);
        return (i == 9'd0) ? 8'h03 :
               (i == 9'd1) ? a[23:16] :
               (i == 9'd2) ? a[15:8] :
               (i == 9'd3) ? a[7:0] : 8'h00;
    endfunction

    // Sequencer FSM: outputs are registered for the state being entered, so each state owns one access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_div       <= '0;
            r_idx       <= '0;
            busy_o      <= 1'b0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
            done_o      <= 1'b0;
            spi_waddr_o <= '0;
            spi_wdata_o <= '0;
            spi_sel_o   <= '0;
            spi_we_o    <= 1'b0;
            spi_raddr_o <= '0;
            spi_rd_o    <= 1'b0;
        end else begin
            spi_we_o    <= 1'b0;
            spi_rd_o    <= 1'b0;
            spi_waddr_o <= '0;
            spi_wdata_o <= '0;
            spi_sel_o   <= '0;
            spi_raddr_o <= '0;
            rvalid_o    <= 1'b0;
            done_o      <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_addr      <= addr_i;
                    r_len       <= len_i;
                    r_div       <= clk_div_i;
                    r_idx       <= '0;
                    busy_o      <= 1'b1;
                    spi_we_o    <= 1'b1;
                    spi_waddr_o <= SPI_CTRL_ADDR;
                    spi_wdata_o <= {16'h0, clk_div_i, 8'h08};
                    spi_sel_o   <= 4'b0011;
                    r_state     <= S_CS_ON;
                end
                S_CS_ON: begin
                    spi_we_o    <= 1'b1;
                    spi_waddr_o <= SPI_DATA_ADDR;
                    spi_wdata_o <= {24'h0, f_byte(r_idx, r_addr)};
                    spi_sel_o   <= 4'b0001;
                    r_state     <= S_LOAD;
                end
                S_LOAD: begin
                    spi_we_o    <= 1'b1;
                    spi_waddr_o <= SPI_CTRL_ADDR;
                    spi_wdata_o <= {16'h0, r_div, 8'h09};
                    spi_sel_o   <= 4'b0011;
                    r_state     <= S_KICK;
                end
                S_KICK: begin
                    spi_rd_o    <= 1'b1;
                    spi_raddr_o <= SPI_STAT_ADDR;
                    r_state     <= S_WB_RD;
                end
                S_WB_RD:  r_state <= S_WB_CHK;
                S_WB_CHK: begin
                    spi_rd_o    <= 1'b1;
                    spi_raddr_o <= SPI_STAT_ADDR;
                    r_state     <= spi_rdata_i[0] ? S_WI_RD : S_WB_RD;
                end
                S_WI_RD:  r_state <= S_WI_CHK;
                S_WI_CHK: begin
                    spi_rd_o    <= 1'b1;
                    spi_raddr_o <= spi_rdata_i[0] ? SPI_STAT_ADDR : SPI_DATA_ADDR;
                    r_state     <= spi_rdata_i[0] ? S_WI_RD : S_DR;
                end
                S_DR:     r_state <= S_DCHK;
                S_DCHK: begin
                    if (r_idx >= 9'd4) begin
                        rdata_o  <= spi_rdata_i[7:0];
                        rvalid_o <= 1'b1;
                    end
                    r_idx       <= r_idx + 9'd1;
                    spi_we_o    <= 1'b1;
                    spi_waddr_o <= (r_idx == w_last) ? SPI_CTRL_ADDR : SPI_DATA_ADDR;
                    spi_wdata_o <= (r_idx == w_last) ? 32'h0 : {24'h0, f_byte(r_idx + 9'd1, r_addr)};
                    spi_sel_o   <= (r_idx == w_last) ? 4'b0011 : 4'b0001;
                    r_state     <= (r_idx == w_last) ? S_CS_OFF : S_LOAD;
                end
                S_CS_OFF: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= S_FIN;
                end
                S_FIN:    r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: scoreboard bench with a behavioural SPI peripheral model
module tb_spi_flash_rd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [23:0] addr_i;
    logic [7:0]  len_i;
    logic [7:0]  clk_div_i;
    logic        busy_o;
    logic [7:0]  rdata_o;
    logic        rvalid_o;
    logic        done_o;
    logic [7:0]  spi_waddr_o;
    logic [31:0] spi_wdata_o;
    logic [3:0]  spi_sel_o;
    logic        spi_we_o;
    logic [7:0]  spi_raddr_o;
    logic        spi_rd_o;
    logic [31:0] spi_rdata_i;

    int checks = 0;
    int failures = 0;
    int dones = 0;
    int cyc = 0;
    int last_we_cyc = -10;

    logic [43:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  base = 8'h00;
    int          k, dly, bcnt;
    logic [64:0] all_out;

    always #5 clk = ~clk;

    spi_flash_rd_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .clk_div_i(clk_div_i), .busy_o(busy_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .done_o(done_o), .spi_waddr_o(spi_waddr_o), .spi_wdata_o(spi_wdata_o),
        .spi_sel_o(spi_sel_o), .spi_we_o(spi_we_o), .spi_raddr_o(spi_raddr_o),
        .spi_rd_o(spi_rd_o), .spi_rdata_i(spi_rdata_i)
    );

    assign all_out = {busy_o, rdata_o, rvalid_o, done_o, spi_waddr_o, spi_wdata_o,
                      spi_sel_o, spi_we_o, spi_raddr_o, spi_rd_o};

    // Peripheral model: busy appears 3 cycles after a kick and lasts 18+4*div cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0;
            dly <= 0;
            bcnt <= 0;
            spi_rdata_i <= 32'h0;
        end else begin
            if (spi_we_o && spi_waddr_o == 8'h04) k <= k + 1;
            if (spi_we_o && spi_waddr_o == 8'h00 && spi_wdata_o[7:0] == 8'h08) k <= 0;
            if (spi_we_o && spi_waddr_o == 8'h00 && spi_wdata_o[0]) begin
                dly <= 3;
                bcnt <= 18 + 4 * int'(spi_wdata_o[15:8]);
            end else if (dly > 0) dly <= dly - 1;
            else if (bcnt > 0) bcnt <= bcnt - 1;
            if (spi_rd_o)
                spi_rdata_i <= (spi_raddr_o == 8'h08) ? {31'h0, (dly == 0 && bcnt > 0)}
                                                      : {24'h0, base + 8'(k - 5)};
        end
    end

    // Monitor: pops expected writes/bytes whenever the DUT presents them
    always @(negedge clk) if (rst_n) begin
        logic [43:0] ew;
        logic [7:0]  er;
        cyc++;
        if (spi_we_o && spi_rd_o) begin
            checks++; failures++;
            $display("FAIL we_rd_overlap cyc=%0d we=1 rd=1 required exclusive", cyc);
        end
        if (spi_we_o) begin
            checks++;
            last_we_cyc = cyc;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got a=%h d=%h s=%h required none", spi_waddr_o, spi_wdata_o, spi_sel_o);
            end else begin
                ew = wq.pop_front();
                if ({spi_waddr_o, spi_wdata_o, spi_sel_o} !== ew) begin
                    failures++;
                    $display("FAIL write got a=%h d=%h s=%h required a=%h d=%h s=%h",
                             spi_waddr_o, spi_wdata_o, spi_sel_o, ew[43:36], ew[35:4], ew[3:0]);
                end
            end
        end
        if (rvalid_o) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected got=%h required none", rdata_o);
            end else begin
                er = rq.pop_front();
                if (rdata_o !== er) begin
                    failures++;
                    $display("FAIL rdata got=%h required=%h", rdata_o, er);
                end
            end
        end
        if (done_o) begin
            dones++;
            checks++;
            if (last_we_cyc != cyc - 1) begin
                failures++;
                $display("FAIL done_timing last_write_cyc=%0d done_cyc=%0d required diff 1", last_we_cyc, cyc);
            end
        end
    end

    task automatic push_op(input logic [23:0] a, input logic [7:0] l, input logic [7:0] dv, input logic [7:0] b);
        int nb;
        logic [7:0] sb;
        nb = (l == 8'd0) ? 256 : int'(l);
        wq.push_back({8'h00, 16'h0, dv, 8'h08, 4'b0011});
        for (int i = 0; i < nb + 4; i++) begin
            sb = (i == 0) ? 8'h03 : (i == 1) ? a[23:16] : (i == 2) ? a[15:8] : (i == 3) ? a[7:0] : 8'h00;
            wq.push_back({8'h04, 24'h0, sb, 4'b0001});
            wq.push_back({8'h00, 16'h0, dv, 8'h09, 4'b0011});
        end
        wq.push_back({8'h00, 32'h0, 4'b0011});
        for (int p = 0; p < nb; p++) rq.push_back(b + 8'(p));
        base = b;
        start_i = 1'b1; addr_i = a; len_i = l; clk_div_i = dv;
        @(negedge clk);
        start_i = 1'b0; addr_i = 24'hFFFFFF; len_i = 8'h05; clk_div_i = 8'h0F;
    endtask

    task automatic run(input logic [23:0] a, input logic [7:0] l, input logic [7:0] dv, input logic [7:0] b, input bit spam);
        int n, d0;
        d0 = dones;
        push_op(a, l, dv, b);
        n = 0;
        while (!done_o && n < 20000) begin
            @(negedge clk);
            n++;
            start_i = spam && busy_o && (n % 7 == 3);
        end
        start_i = 1'b0;
        checks++;
        if (!done_o) begin failures++; $display("FAIL done_timeout cycles=%0d required done within 20000", n); end
        checks++;
        if (wq.size() != 0) begin failures++; $display("FAIL writes_left got=%0d required 0", wq.size()); end
        checks++;
        if (rq.size() != 0) begin failures++; $display("FAIL bytes_left got=%0d required 0", rq.size()); end
        repeat (3) @(negedge clk);
        checks++;
        if (dones != d0 + 1) begin failures++; $display("FAIL done_count got=%0d required=%0d", dones - d0, 1); end
        wq.delete();
        rq.delete();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_i = 1'b1; addr_i = 24'h123456; len_i = 8'd1; clk_div_i = 8'd0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (all_out !== 65'h0) begin failures++; $display("FAIL reset_outputs got=%h required 0", all_out); end
        end
        start_i = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (spi_we_o || spi_rd_o) begin failures++; $display("FAIL idle_access we=%b rd=%b required 0", spi_we_o, spi_rd_o); end
        end
        run(24'h123456, 8'd1, 8'd0, 8'hA5, 1'b0);
        run(24'h000100, 8'd0, 8'd0, 8'h00, 1'b0);
        run(24'h0A0B0C, 8'd2, 8'd3, 8'h40, 1'b0);
        run(24'h654321, 8'd2, 8'd1, 8'h77, 1'b1);
        push_op(24'hABCDEF, 8'd4, 8'd1, 8'h30);
        n = 0;
        while (k != 6 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (k != 6) begin failures++; $display("FAIL byte5_timeout k=%0d required 6", k); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 65'h0) begin failures++; $display("FAIL async_reset got=%h required 0", all_out); end
        wq.delete();
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(24'h00FF10, 8'd3, 8'd0, 8'h10, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
